mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Arbitrates the single shared multi-cycle main memory between the I-cache miss path and the D-cache miss/write-through path.
- On a cache miss, sequences a full block fill as a burst of pipelined word reads.
- On a D-side store, issues a single write-through word write.
- Sits between both cache controllers and the memory model. The pipeline stalls while the requesting side's done pulse is outstanding.

Parameters:
- LATENCY, 4, cycles from mem_en (read) to matching mem_data_valid; fixed, in-order.
- BLOCK_WORDS, 8, 16-bit words per cache block (16-byte block).
- ADDR_W, 16, byte address width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- i_req  in  1  I-cache miss request; held high until i_done
- i_addr  in  16  I-side miss byte address
- d_req  in  1  D-side request; held high until d_done
- d_wr  in  1  1 = write-through word write, 0 = block fill
- d_addr  in  16  D-side byte address
- d_wdata  in  16  D-side write data
- mem_en  out  1  memory access strobe
- mem_wr  out  1  1 = write, 0 = read (valid with mem_en)
- mem_addr  out  16  memory byte address, word aligned
- mem_wdata  out  16  write data
- mem_rdata  in  16  read return data
- mem_data_valid  in  1  read return strobe
- fill_data  out  16  returned word, forwarded to the owning cache
- fill_idx  out  3  word index within the block for fill_data
- i_fill_we  out  1  I-cache data-array write enable
- d_fill_we  out  1  D-cache data-array write enable
- i_done  out  1  one-cycle pulse: I fill complete
- d_done  out  1  one-cycle pulse: D fill or write complete
- busy  out  1  high in any non-IDLE state

Behaviour:
- Reset (sync, rst=1 at a clk edge): state IDLE. All outputs 0. Issue and return counters 0. Owner cleared.
- rst mid-fill: state returns to IDLE immediately. Later stray mem_data_valid pulses are ignored (no fill_we, no done) until the next grant.
- States: IDLE, FILL, WRITE, DONE.
- Arbitration in IDLE:
  - d_req has fixed priority over i_req.
  - Grant is registered: the state change occurs at the clk edge where a req is seen.
  - No preemption once granted.
  - A request arriving while busy waits in IDLE for evaluation.
- IDLE -> WRITE (d_req & d_wr):
  - In WRITE: mem_en=1, mem_wr=1 for exactly one cycle, mem_addr = {d_addr[15:1],1'b0}, mem_wdata = d_wdata.
  - Then -> DONE.
- IDLE -> FILL (d_req & !d_wr, else i_req):
  - Latch owner and base = {addr[15:4],4'b0}.
  - Issue phase: mem_en=1, mem_wr=0 for BLOCK_WORDS consecutive cycles, mem_addr = base + 2*k, k = 0..7. mem_en drops after k=7.
  - Collection phase: each mem_data_valid drives fill_data = mem_rdata, fill_idx = return count, and the owner's fill_we = 1 in the same cycle (combinational pass-through).
  - After the 8th return -> DONE.
  - The return counter runs independently of the issue counter; returns overlap issue.
- DONE: one cycle. The owner's done = 1 -> IDLE.
  - A requester must drop its req in the cycle it sees done. A req still high in the following IDLE cycle is treated as a new request.
- Fill timing: grant edge at cycle 0. Issues in cycles 1..8. Returns in cycles 1+LATENCY..8+LATENCY. Done in cycle 9+LATENCY (cycle 13 at default).
- Write timing: WRITE in cycle 1, d_done in cycle 2.
- Address arithmetic: base + 2*k is computed within the block only (low 4 bits). There is no carry into upper bits and no wrap across blocks.
- Simultaneous d_req & i_req in IDLE: D served first. The I request is served after D's DONE cycle if i_req is still asserted.
- mem_data_valid in IDLE or WRITE: ignored.
- fill_we is never asserted for the non-owner.

Decomposition:
- Shared package mem_pkg:
  - state enum {IDLE, FILL, WRITE, DONE}
  - owner encoding {OWN_I, OWN_D}
  - BLOCK_WORDS, LATENCY, block offset width constants
- One natural sub-module: fill_counter. It is an up-counter with enable, clear and terminal-count flag, instantiated twice (issue count, return count).

Test Plan:
- i_req=1, i_addr=0x1236, LATENCY=4:
  - mem_addr sequence 0x1230..0x123E over cycles 1..8.
  - i_fill_we pulses with fill_idx 0..7 in cycles 5..12.
  - i_done in cycle 13; busy falls in cycle 14.
- d_req=1, d_wr=1, d_addr=0x0401, d_wdata=0xBEEF:
  - mem_en=mem_wr=1, mem_addr=0x0400, mem_wdata=0xBEEF in cycle 1.
  - d_done in cycle 2; no fill_we asserted.
- i_req and d_req (fill, d_addr=0x2000) rise in the same cycle:
  - D fill addresses 0x2000..0x200E complete with d_done.
  - The I fill begins at the first IDLE cycle after D's DONE; i_fill_we never overlaps d_fill_we.
- d_req (write) asserted during an I fill: no mem_wr until after i_done; the write is issued exactly once afterwards.
- rst=1 in cycle 6 of a fill:
  - Next cycle all outputs 0, state IDLE.
  - The remaining mem_data_valid pulses produce no fill_we and no done.
- Requester holds i_req for one cycle past i_done: a second complete 8-word fill is issued (req-held semantics).

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and geometry for the main-memory arbiter: FSM states, owner
// encoding, block size and the address masks used to form fill/write addresses.
package mem_pkg;

  localparam int ADDR_W      = 16;
  localparam int DATA_W      = 16;
  localparam int BLOCK_WORDS = 8;
  localparam int LATENCY     = 4;
  localparam int IDX_W       = $clog2(BLOCK_WORDS);
  localparam int OFF_W       = IDX_W + 1;
  localparam int ISS_W       = IDX_W + 1;

  localparam logic [ADDR_W-1:0] BLOCK_MASK = ~ADDR_W'((1 << OFF_W) - 1);
  localparam logic [ADDR_W-1:0] WORD_MASK  = ~ADDR_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/fill_counter.sv
// Up-counter with synchronous clear, count enable and a terminal-count flag
// that is high while the count equals TERM.
module fill_counter #(
  parameter int WIDTH = 3,
  parameter int TERM  = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count,
  output logic             o_tc
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == WIDTH'(TERM));

endmodule

// File: rtl/mem_arbiter.sv
// Shares the multi-cycle main memory between the I-cache miss path and the
// D-cache miss/write-through path; D has fixed priority, no preemption.
module mem_arbiter
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_data_valid,
  output logic [DATA_W-1:0] fill_data,
  output logic [IDX_W-1:0]  fill_idx,
  output logic              i_fill_we,
  output logic              d_fill_we,
  output logic              i_done,
  output logic              d_done,
  output logic              busy
);

  state_t            r_state;
  state_t            w_next;
  owner_t            r_owner;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic              w_grant;
  logic              w_cnt_clr;
  logic              w_iss_en;
  logic              w_ret_en;
  logic [ISS_W-1:0]  w_iss_cnt;
  logic              w_iss_tc;
  logic [IDX_W-1:0]  w_ret_cnt;
  logic              w_ret_tc;

  assign w_grant   = (r_state == IDLE) && (d_req || i_req);
  assign w_cnt_clr = (r_state != FILL);
  assign w_iss_en  = (r_state == FILL) && !w_iss_tc;
  assign w_ret_en  = (r_state == FILL) && mem_data_valid;
  assign busy      = (r_state != IDLE);

  // Issue and return counts run independently so returns overlap issue.
  fill_counter #(.WIDTH(ISS_W), .TERM(BLOCK_WORDS)) u_iss_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_cnt_clr),
    .i_en    (w_iss_en),
    .o_count (w_iss_cnt),
    .o_tc    (w_iss_tc)
  );

  fill_counter #(.WIDTH(IDX_W), .TERM(BLOCK_WORDS - 1)) u_ret_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_cnt_clr),
    .i_en    (w_ret_en),
    .o_count (w_ret_cnt),
    .o_tc    (w_ret_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= OWN_I;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_owner <= d_req ? OWN_D : OWN_I;
      end
    end
  end

  // Address holds the block base for fills or the aligned word for writes.
  always_ff @(posedge clk) begin
    if (w_grant) begin
      if (d_req) begin
        r_addr <= d_wr ? (d_addr & WORD_MASK) : (d_addr & BLOCK_MASK);
      end else begin
        r_addr <= i_addr & BLOCK_MASK;
      end
      r_wdata <= d_wdata;
    end
  end

  always_comb begin
    w_next    = r_state;
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    fill_data = '0;
    fill_idx  = '0;
    i_fill_we = 1'b0;
    d_fill_we = 1'b0;
    i_done    = 1'b0;
    d_done    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (d_req) begin
          w_next = d_wr ? WRITE : FILL;
        end else if (i_req) begin
          w_next = FILL;
        end
      end
      FILL: begin
        if (w_iss_en) begin
          mem_en   = 1'b1;
          mem_addr = r_addr | (ADDR_W'(w_iss_cnt) << 1);
        end
        if (mem_data_valid) begin
          fill_data = mem_rdata;
          fill_idx  = w_ret_cnt;
          i_fill_we = (r_owner == OWN_I);
          d_fill_we = (r_owner == OWN_D);
          if (w_ret_tc) begin
            w_next = DONE;
          end
        end
      end
      WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
        w_next    = DONE;
      end
      DONE: begin
        i_done = (r_owner == OWN_I);
        d_done = (r_owner == OWN_D);
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level model predicts every
// memory access, fill write and done pulse with its cycle; a monitor compares.
module tb_mem_arbiter;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_wr;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_data_valid;
  logic [15:0] fill_data;
  logic [2:0]  fill_idx;
  logic        i_fill_we, d_fill_we, i_done, d_done, busy;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [15:0] salt;

  typedef struct { logic wr; logic [15:0] addr; logic [15:0] wdata; int cyc; } mem_t;
  typedef struct { logic own_d; logic [2:0] idx; logic [15:0] data; int cyc; } fill_t;
  typedef struct { logic own_d; int cyc; } done_t;

  mem_t  qm[$];
  fill_t qf[$];
  done_t qd[$];

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid),
    .fill_data(fill_data), .fill_idx(fill_idx),
    .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
    .i_done(i_done), .d_done(d_done), .busy(busy)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  function automatic logic [15:0] mem_f(input logic [15:0] a);
    return (a * 16'h9E37) ^ salt;
  endfunction

  // Memory model: read issued in cycle t returns in cycle t+LAT.
  initial begin
    logic        pv[0:LAT];
    logic [15:0] pa[0:LAT];
    for (int i = 0; i <= LAT; i++) begin pv[i] = 1'b0; pa[i] = '0; end
    mem_data_valid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      for (int i = LAT; i > 0; i--) begin pv[i] = pv[i-1]; pa[i] = pa[i-1]; end
      pv[0] = (mem_en === 1'b1) && (mem_wr === 1'b0);
      pa[0] = mem_addr;
      mem_data_valid = pv[LAT];
      mem_rdata = pv[LAT] ? mem_f(pa[LAT]) : 16'($urandom);
    end
  end

  // Monitor: every DUT event must match the head of its expectation queue.
  initial forever begin
    @(negedge clk);
    if (mem_en === 1'b1) begin
      checks++;
      if (qm.size() == 0) begin
        errors++;
        $display("FAIL mem_unexpected: got wr=%0b addr=%h at cyc %0d, expected no access", mem_wr, mem_addr, cyc);
      end else begin
        mem_t e;
        e = qm.pop_front();
        if (mem_wr !== e.wr || mem_addr !== e.addr || cyc != e.cyc || (e.wr && mem_wdata !== e.wdata)) begin
          errors++;
          $display("FAIL mem_access: got wr=%0b addr=%h wdata=%h cyc=%0d, expected wr=%0b addr=%h wdata=%h cyc=%0d",
                   mem_wr, mem_addr, mem_wdata, cyc, e.wr, e.addr, e.wdata, e.cyc);
        end
      end
    end
    if (i_fill_we === 1'b1 || d_fill_we === 1'b1) begin
      checks++;
      if (i_fill_we === 1'b1 && d_fill_we === 1'b1) begin
        errors++;
        $display("FAIL fill_both: got i_fill_we=1 d_fill_we=1 at cyc %0d, expected at most one", cyc);
      end else if (qf.size() == 0) begin
        errors++;
        $display("FAIL fill_unexpected: got d_side=%0b idx=%0d at cyc %0d, expected no fill", d_fill_we, fill_idx, cyc);
      end else begin
        fill_t f;
        f = qf.pop_front();
        if (d_fill_we !== f.own_d || fill_idx !== f.idx || fill_data !== f.data || cyc != f.cyc) begin
          errors++;
          $display("FAIL fill_word: got d_side=%0b idx=%0d data=%h cyc=%0d, expected d_side=%0b idx=%0d data=%h cyc=%0d",
                   d_fill_we, fill_idx, fill_data, cyc, f.own_d, f.idx, f.data, f.cyc);
        end
      end
    end
    if (i_done === 1'b1 || d_done === 1'b1) begin
      checks++;
      if (qd.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: got i_done=%0b d_done=%0b at cyc %0d, expected none", i_done, d_done, cyc);
      end else begin
        done_t d;
        d = qd.pop_front();
        if (d_done !== d.own_d || i_done !== !d.own_d || cyc != d.cyc) begin
          errors++;
          $display("FAIL done_pulse: got i_done=%0b d_done=%0b cyc=%0d, expected d_side=%0b cyc=%0d",
                   i_done, d_done, cyc, d.own_d, d.cyc);
        end
      end
    end
  end

  // Reference model: a fill granted in cycle t0 issues in t0+1..t0+8,
  // returns in t0+1+LAT.., and signals done in t0+9+LAT.
  task automatic push_fill(input logic own_d, input logic [15:0] a, input int t0,
                           input int n_iss, input int n_ret, input logic with_done);
    logic [15:0] base;
    base = a & 16'hFFF0;
    for (int k = 0; k < n_iss; k++)
      qm.push_back('{1'b0, base + 16'(2 * k), 16'h0, t0 + 1 + k});
    for (int k = 0; k < n_ret; k++)
      qf.push_back('{own_d, 3'(k), mem_f(base + 16'(2 * k)), t0 + 1 + LAT + k});
    if (with_done) qd.push_back('{own_d, t0 + 9 + LAT});
  endtask

  task automatic push_write(input logic [15:0] a, input logic [15:0] wd, input int t0);
    qm.push_back('{1'b1, a & 16'hFFFE, wd, t0 + 1});
    qd.push_back('{1'b1, t0 + 2});
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic drive_i(input logic [15:0] a);
    i_addr = a; i_req = 1'b1;
  endtask

  task automatic drive_d(input logic wr, input logic [15:0] a, input logic [15:0] wd);
    d_addr = a; d_wdata = wd; d_wr = wr; d_req = 1'b1;
  endtask

  task automatic hs_i(input int ndone);
    int seen = 0;
    int n = 0;
    while (seen < ndone && n < 200) begin
      @(negedge clk); n++;
      if (i_done === 1'b1) seen++;
    end
    i_req = 1'b0;
    checks++;
    if (seen < ndone) begin
      errors++;
      $display("FAIL i_timeout: got %0d i_done pulses, expected %0d", seen, ndone);
    end
  endtask

  task automatic hs_d(input int ndone);
    int seen = 0;
    int n = 0;
    while (seen < ndone && n < 200) begin
      @(negedge clk); n++;
      if (d_done === 1'b1) seen++;
    end
    d_req = 1'b0; d_wr = 1'b0;
    checks++;
    if (seen < ndone) begin
      errors++;
      $display("FAIL d_timeout: got %0d d_done pulses, expected %0d", seen, ndone);
    end
  endtask

  task automatic check_idle(input string nm);
    logic [57:0] v;
    v = {mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_idx,
         i_fill_we, d_fill_we, i_done, d_done, busy};
    checks++;
    if (v !== '0) begin
      errors++;
      $display("FAIL %s: outputs=%h, expected all zero", nm, v);
    end
  endtask

  task automatic check_bit(input string nm, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", nm, got, exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at cyc %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    salt = 16'($urandom);
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset_outputs");
    next_cycle();
    rst = 1'b0;

    // Directed I fill with exact cycle numbers.
    next_cycle(); t0 = cyc;
    push_fill(1'b0, 16'h1236, t0, 8, 8, 1'b1);
    drive_i(16'h1236);
    fork
      hs_i(1);
      begin
        do @(negedge clk); while (cyc != t0 + 13);
        check_bit("busy_in_done", busy, 1'b1);
        @(negedge clk);
        check_bit("busy_after_done", busy, 1'b0);
      end
    join

    // Directed write-through.
    next_cycle(); t0 = cyc;
    push_write(16'h0401, 16'hBEEF, t0);
    drive_d(1'b1, 16'h0401, 16'hBEEF);
    hs_d(1);

    // Simultaneous requests: D fill first, then I.
    next_cycle(); t0 = cyc;
    push_fill(1'b1, 16'h2000, t0, 8, 8, 1'b1);
    push_fill(1'b0, 16'h5A5A, t0 + 14, 8, 8, 1'b1);
    drive_d(1'b0, 16'h2000, 16'h0000);
    drive_i(16'h5A5A);
    fork hs_d(1); hs_i(1); join

    // Write arriving during an I fill waits for i_done.
    next_cycle(); t0 = cyc;
    push_fill(1'b0, 16'h7F10, t0, 8, 8, 1'b1);
    push_write(16'hC0DF, 16'h1357, t0 + 14);
    drive_i(16'h7F10);
    fork
      hs_i(1);
      begin repeat (3) next_cycle(); drive_d(1'b1, 16'hC0DF, 16'h1357); hs_d(1); end
    join

    // Reset in cycle 6 of a fill; stray returns must be ignored.
    next_cycle(); t0 = cyc;
    push_fill(1'b0, 16'h3344, t0, 6, 2, 1'b0);
    drive_i(16'h3344);
    while (cyc != t0 + 6) next_cycle();
    rst = 1'b1; i_req = 1'b0;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check_idle("after_midfill_rst");
    repeat (LAT + 4) next_cycle();
    @(negedge clk);
    check_idle("after_stray_returns");

    // Request held past i_done produces a second full fill.
    next_cycle(); t0 = cyc;
    push_fill(1'b0, 16'h0ABC, t0, 8, 8, 1'b1);
    push_fill(1'b0, 16'h0ABC, t0 + 14, 8, 8, 1'b1);
    drive_i(16'h0ABC);
    hs_i(2);

    // Randomized mix of transactions.
    for (int n = 0; n < 30; n++) begin
      int kind, dly;
      logic [15:0] ia, da, dw;
      logic dwr;
      repeat ($urandom_range(0, 2)) next_cycle();
      next_cycle(); t0 = cyc;
      ia = 16'($urandom); da = 16'($urandom); dw = 16'($urandom);
      dwr = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 4);
      case (kind)
        0: begin push_fill(1'b0, ia, t0, 8, 8, 1'b1); drive_i(ia); hs_i(1); end
        1: begin push_fill(1'b1, da, t0, 8, 8, 1'b1); drive_d(1'b0, da, dw); hs_d(1); end
        2: begin push_write(da, dw, t0); drive_d(1'b1, da, dw); hs_d(1); end
        3: begin
          if (dwr) push_write(da, dw, t0);
          else push_fill(1'b1, da, t0, 8, 8, 1'b1);
          push_fill(1'b0, ia, t0 + (dwr ? 3 : 14), 8, 8, 1'b1);
          drive_d(dwr, da, dw);
          drive_i(ia);
          fork hs_d(1); hs_i(1); join
        end
        default: begin
          dly = $urandom_range(1, 12);
          push_fill(1'b0, ia, t0, 8, 8, 1'b1);
          push_write(da, dw, t0 + 14);
          drive_i(ia);
          fork
            hs_i(1);
            begin repeat (dly) next_cycle(); drive_d(1'b1, da, dw); hs_d(1); end
          join
        end
      endcase
    end

    repeat (LAT + 4) next_cycle();
    @(negedge clk);
    checks++;
    if (qm.size() != 0) begin errors++; $display("FAIL mem_queue_left: got %0d pending, expected 0", qm.size()); end
    checks++;
    if (qf.size() != 0) begin errors++; $display("FAIL fill_queue_left: got %0d pending, expected 0", qf.size()); end
    checks++;
    if (qd.size() != 0) begin errors++; $display("FAIL done_queue_left: got %0d pending, expected 0", qd.size()); end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
